// File: rtl/clk_gen_bank.sv
// Bank of counter-based clock/strobe generators sharing one master clock and one sync pulse.
// Latency: all outputs registered; first rise 1+D edges after the edge that samples sync_start.
// No backpressure: enable is level-sensitive, stops are deferred to the next period boundary.
module clk_gen_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*CNT_W-1:0] period,
  input  logic [CHANNELS*CNT_W-1:0] high_time,
  input  logic [CHANNELS*CNT_W-1:0] phase,
  input  logic                      sync_start,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       rise_stb,
  output logic [CHANNELS-1:0]       fall_stb,
  output logic [CHANNELS-1:0]       running,
  output logic [CHANNELS-1:0]       cfg_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_DELAY = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [2:0]       st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] p_lat;
    logic [CNT_W-1:0] h_lat;
    logic [CNT_W-1:0] d_lat;
    logic [CNT_W-1:0] p_in;
    logic [CNT_W-1:0] h_in;
    logic [CNT_W-1:0] d_in;
    logic [CNT_W-1:0] h_fix;
    logic [CNT_W-1:0] cnt_inc;
    logic             at_wrap;
    logic             clk_d;
    logic             err_q;
    logic             clk_q;
    logic             rise_q;
    logic             fall_q;

    assign p_in = period[g*CNT_W +: CNT_W];
    assign h_in = high_time[g*CNT_W +: CNT_W];
    assign d_in = phase[g*CNT_W +: CNT_W];

    // Clamp the requested high time into 1..P-1 so every period has both a high and a low phase.
    always_comb begin
      h_fix = h_in;
      if (h_fix == '0) h_fix = CNT_W'(1);
      if ((p_in >= CNT_W'(2)) && (h_fix >= p_in)) h_fix = p_in - CNT_W'(1);
    end

    // Period counter wraps at P-1; the pre-increment count decides the next clock level,
    // which puts the first rise one edge after the counter starts at zero.
    assign at_wrap = (cnt == (p_lat - CNT_W'(1)));
    assign cnt_inc = at_wrap ? '0 : (cnt + CNT_W'(1));
    assign clk_d   = ((st == S_RUN) || (st == S_DRAIN)) && (cnt < h_lat);

    // Output registers: clock level plus edge strobes aligned with its transitions.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        clk_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        clk_q  <= clk_d;
        rise_q <= clk_d & ~clk_q;
        fall_q <= ~clk_d & clk_q;
      end
    end

    // Channel control: arm/latch config, phase delay, run and drain to the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st    <= S_IDLE;
        cnt   <= '0;
        p_lat <= '0;
        h_lat <= '0;
        d_lat <= '0;
        err_q <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
            cnt <= '0;
            if (enable[g]) begin
              st    <= S_ARMED;
              p_lat <= p_in;
              h_lat <= h_fix;
              d_lat <= d_in;
              err_q <= (p_in < CNT_W'(2));
            end
          end
          S_ARMED: begin
            if (!enable[g]) begin
              st <= S_IDLE;
            end else if (sync_start && !err_q) begin
              if (d_lat == '0) begin
                st  <= S_RUN;
                cnt <= '0;
              end else begin
                st  <= S_DELAY;
                cnt <= d_lat - CNT_W'(1);
              end
            end
          end
          S_DELAY: begin
            if (!enable[g]) begin
              st  <= S_IDLE;
              cnt <= '0;
            end else if (cnt == '0) begin
              st <= S_RUN;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_RUN: begin
            cnt <= cnt_inc;
            if (!enable[g]) st <= S_DRAIN;
          end
          S_DRAIN: begin
            cnt <= cnt_inc;
            if (at_wrap) st <= S_IDLE;
          end
          default: begin
            st  <= S_IDLE;
            cnt <= '0;
          end
        endcase
      end
    end

    assign clk_out[g]  = clk_q;
    assign rise_stb[g] = rise_q;
    assign fall_stb[g] = fall_q;
    assign cfg_err[g]  = err_q;
    assign running[g]  = (st == S_DELAY) || (st == S_RUN) || (st == S_DRAIN);
  end

endmodule

// File: tb/tb_clk_gen_bank.sv
// Self-checking bench for clk_gen_bank: vector table, directed corner sequences, random run.
// Expected waveforms come from an edge-indexed model: clk = ((t - t_first_rise) mod P) < H.
// Inputs change after the falling edge, outputs are sampled on the falling edge.
module tb_clk_gen_bank;
  localparam int CH = 4;
  localparam int CW = 16;

  logic              clk;
  logic              rst_n;
  logic [CH-1:0]     enable;
  logic [CH*CW-1:0]  period;
  logic [CH*CW-1:0]  high_time;
  logic [CH*CW-1:0]  phase;
  logic              sync_start;
  logic [CH-1:0]     clk_out;
  logic [CH-1:0]     rise_stb;
  logic [CH-1:0]     fall_stb;
  logic [CH-1:0]     running;
  logic [CH-1:0]     cfg_err;

  clk_gen_bank #(.CHANNELS(CH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
    .high_time(high_time), .phase(phase), .sync_start(sync_start),
    .clk_out(clk_out), .rise_stb(rise_stb), .fall_stb(fall_stb),
    .running(running), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Model state: 0 idle, 1 armed, 2 active (delay/run/drain)
  int ms [CH];
  int mp [CH];
  int mh [CH];
  int md [CH];
  int ts [CH];
  int t0 [CH];
  int stop_e [CH];
  bit merr [CH];
  bit mclk [CH];
  bit mrise [CH];
  bit mfall [CH];
  bit mrun [CH];

  typedef struct packed {
    logic       en;
    logic       sync;
    logic [3:0] exp;   // {clk_out, rise_stb, fall_stb, running} of channel 0
  } vec_t;
  vec_t tbl [0:14];

  int r_first [3];
  int f2_first;
  int cnt_a;
  int cnt_b;
  bit seen;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      ms[c] = 0; mp[c] = 0; mh[c] = 0; md[c] = 0; ts[c] = 0; t0[c] = 0; stop_e[c] = -1;
      merr[c] = 0; mclk[c] = 0; mrise[c] = 0; mfall[c] = 0; mrun[c] = 0;
    end
  endtask

  task automatic set_cfg(input int c, input int p, input int h, input int d);
    period[c*CW +: CW]    = CW'(p);
    high_time[c*CW +: CW] = CW'(h);
    phase[c*CW +: CW]     = CW'(d);
  endtask

  // One master-clock edge of the reference: rules applied to absolute edge numbers.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      int pos;
      bit nclk;
      case (ms[c])
        0: if (enable[c]) begin
          ms[c] = 1;
          mp[c] = int'(period[c*CW +: CW]);
          mh[c] = int'(high_time[c*CW +: CW]);
          md[c] = int'(phase[c*CW +: CW]);
          if (mh[c] == 0) mh[c] = 1;
          if (mp[c] >= 2 && mh[c] >= mp[c]) mh[c] = mp[c] - 1;
          merr[c] = (mp[c] < 2);
        end
        1: if (!enable[c]) ms[c] = 0;
           else if (sync_start && !merr[c]) begin
             ms[c] = 2; ts[c] = edge_n; t0[c] = edge_n + 1 + md[c]; stop_e[c] = -1;
           end
        default: begin
          if (stop_e[c] >= 0) begin
            if (edge_n == stop_e[c]) ms[c] = 0;
          end else if (!enable[c]) begin
            if (edge_n <= ts[c] + md[c]) ms[c] = 0;   // still in the start delay: abort
            else begin
              pos = (edge_n - t0[c]) % mp[c];
              stop_e[c] = edge_n + ((pos == mp[c] - 1) ? mp[c] : (mp[c] - 1 - pos));
            end
          end
        end
      endcase
      nclk = (ms[c] == 2) && (edge_n >= t0[c]) && (((edge_n - t0[c]) % mp[c]) < mh[c]);
      mrise[c] = nclk && !mclk[c];
      mfall[c] = !nclk && mclk[c];
      mclk[c]  = nclk;
      mrun[c]  = (ms[c] == 2);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    edge_n++;
    model_step();
    @(negedge clk);
    for (int c = 0; c < CH; c++)
      check($sformatf("model ch%0d edge %0d", c, edge_n),
            32'({clk_out[c], rise_stb[c], fall_stb[c], running[c], cfg_err[c]}),
            32'({mclk[c], mrise[c], mfall[c], mrun[c], merr[c]}));
  endtask

  initial begin
    // Basic run P=4 H=2 D=0: arm, sync, two periods, disable exactly at a wrap (full drain)
    tbl[0]  = {1'b1, 1'b0, 4'b0000};
    tbl[1]  = {1'b1, 1'b1, 4'b0001};
    tbl[2]  = {1'b1, 1'b0, 4'b1101};
    tbl[3]  = {1'b1, 1'b0, 4'b1001};
    tbl[4]  = {1'b1, 1'b0, 4'b0011};
    tbl[5]  = {1'b1, 1'b0, 4'b0001};
    tbl[6]  = {1'b1, 1'b0, 4'b1101};
    tbl[7]  = {1'b1, 1'b0, 4'b1001};
    tbl[8]  = {1'b1, 1'b0, 4'b0011};
    tbl[9]  = {1'b0, 1'b0, 4'b0001};
    tbl[10] = {1'b0, 1'b0, 4'b1101};
    tbl[11] = {1'b0, 1'b0, 4'b1001};
    tbl[12] = {1'b0, 1'b0, 4'b0011};
    tbl[13] = {1'b0, 1'b0, 4'b0000};
    tbl[14] = {1'b0, 1'b0, 4'b0000};

    rst_n = 1'b0; enable = '0; sync_start = 1'b0; period = '0; high_time = '0; phase = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset outputs", 32'({clk_out, rise_stb, fall_stb, running, cfg_err}), 32'd0);
    rst_n = 1'b1;
    repeat (100) cycle();

    // Vector table on channel 0
    set_cfg(0, 4, 2, 0);
    for (int i = 0; i <= 14; i++) begin
      enable[0] = tbl[i].en;
      sync_start = tbl[i].sync;
      cycle();
      check($sformatf("table row %0d", i),
            32'({clk_out[0], rise_stb[0], fall_stb[0], running[0]}), 32'(tbl[i].exp));
    end
    sync_start = 1'b0;

    // Phase alignment: D = 0, 2, 6 on P=8 H=4
    set_cfg(0, 8, 4, 0); set_cfg(1, 8, 4, 2); set_cfg(2, 8, 4, 6);
    enable[2:0] = 3'b111;
    cycle();
    sync_start = 1'b1;
    cycle();
    sync_start = 1'b0;
    cnt_a = edge_n;
    r_first = '{-1, -1, -1};
    f2_first = -1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      for (int c = 0; c < 3; c++) if (rise_stb[c] && r_first[c] < 0) r_first[c] = edge_n;
      if (fall_stb[2] && f2_first < 0) f2_first = edge_n;
    end
    check("phase ch0 first rise", 32'(r_first[0] - cnt_a), 32'd1);
    check("phase ch1 rise offset", 32'(r_first[1] - r_first[0]), 32'd2);
    check("phase ch2 rise offset", 32'(r_first[2] - r_first[0]), 32'd6);
    check("phase ch2 first fall", 32'(f2_first - cnt_a), 32'd11);
    enable = '0;
    repeat (20) cycle();

    // Clean stop: P=5 H=3, enable dropped when the counter sits at 1
    set_cfg(0, 5, 3, 0);
    enable[0] = 1'b1;
    cycle();
    sync_start = 1'b1;
    cycle();
    sync_start = 1'b0;
    cycle();
    enable[0] = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      cnt_a += int'(clk_out[0]);
      cnt_b += int'(running[0]);
    end
    check("stop high cycles", 32'(cnt_a), 32'd2);
    check("stop running cycles", 32'(cnt_b), 32'd3);
    check("stop final running", 32'(running[0]), 32'd0);

    // Invalid period on channel 3, then a valid re-arm clears the flag
    set_cfg(3, 1, 1, 0);
    enable[3] = 1'b1;
    cycle();
    check("cfg_err set", 32'(cfg_err[3]), 32'd1);
    sync_start = 1'b1;
    cycle();
    sync_start = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      cnt_a += int'(clk_out[3]) + int'(running[3]);
    end
    check("cfg_err no output", 32'(cnt_a), 32'd0);
    enable[3] = 1'b0;
    cycle();
    check("cfg_err sticky", 32'(cfg_err[3]), 32'd1);
    set_cfg(3, 4, 2, 0);
    enable[3] = 1'b1;
    cycle();
    check("cfg_err cleared", 32'(cfg_err[3]), 32'd0);
    enable[3] = 1'b0;
    repeat (3) cycle();

    // High-time clamping, and period changes ignored while running
    set_cfg(0, 6, 9, 0); set_cfg(1, 6, 0, 0);
    enable[1:0] = 2'b11;
    cycle();
    sync_start = 1'b1;
    cycle();
    sync_start = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      cnt_a += int'(clk_out[0]);
      cnt_b += int'(clk_out[1]);
    end
    check("clamp H>=P high count", 32'(cnt_a), 32'd5);
    check("clamp H=0 high count", 32'(cnt_b), 32'd1);
    set_cfg(0, 3, 1, 0);
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      cnt_a += int'(clk_out[0]);
    end
    check("cfg change in run ignored", 32'(cnt_a), 32'd5);
    enable = '0;
    repeat (12) cycle();

    // Asynchronous reset while clk_out is high
    set_cfg(0, 4, 2, 0);
    enable[0] = 1'b1;
    cycle();
    sync_start = 1'b1;
    cycle();
    sync_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = clk_out[0];
    end
    check("async pre clk_out high", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    enable = '0;
    #1;
    check("async reset outputs", 32'({clk_out, rise_stb, fall_stb, running, cfg_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sync_start = 1'b1;
    cycle();
    sync_start = 1'b0;
    repeat (4) cycle();
    check("after reset no autostart", 32'(running[0]), 32'd0);
    enable[0] = 1'b1;
    cycle();
    sync_start = 1'b1;
    cycle();
    sync_start = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      cnt_a += int'(clk_out[0]);
    end
    check("restart after reset", 32'(cnt_a), 32'd2);
    enable = '0;
    repeat (10) cycle();

    // Random enables, sync pulses and configs on all channels
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        set_cfg(c, int'($urandom_range(9, 2)), int'($urandom_range(10, 0)), int'($urandom_range(6, 0)));
        if ($urandom_range(11, 0) == 0) enable[c] = ~enable[c];
      end
      sync_start = ($urandom_range(7, 0) == 0);
      cycle();
    end
    enable = '0;
    sync_start = 1'b0;
    repeat (30) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
